// File: rtl/vga_timing_gen_pkg.sv
// Shared timing types for the VGA timing generator: one record per axis,
// two per mode, plus the default 640x480 and 800x600 mode constants.
package vga_timing_gen_pkg;

  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] act;
    logic [TW-1:0] fp;
    logic [TW-1:0] sync;
    logic [TW-1:0] bp;
    logic          pol;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  localparam mode_t MODE0_DEF = '{
    h: '{act: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48, pol: 1'b0},
    v: '{act: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33, pol: 1'b0}
  };

  localparam mode_t MODE1_DEF = '{
    h: '{act: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88, pol: 1'b1},
    v: '{act: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23, pol: 1'b1}
  };

  function automatic int total(timing_t t);
    return int'(t.act) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter with its sync window and
// active-area flag decoded from the current count.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int CW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  input  timing_t       tm_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          active_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] act_w, sync_start, sync_end, last_cnt;

  assign act_w      = CW'(tm_i.act);
  assign sync_start = act_w + CW'(tm_i.fp);
  assign sync_end   = sync_start + CW'(tm_i.sync);
  assign last_cnt   = sync_end + CW'(tm_i.bp) - CW'(1);

  assign wrap_o = (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // sync_end is exclusive, so the window spans exactly tm_i.sync counts
  assign sync_o   = (cnt_q >= sync_start && cnt_q < sync_end) ? tm_i.pol : ~tm_i.pol;
  assign active_o = (cnt_q < act_w);
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator: H/V axis counters advanced by a pixel clock
// enable, with all outputs registered one ce behind the counter state.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CW      = 11,
  parameter int H0_ACT  = int'(MODE0_DEF.h.act),
  parameter int H0_FP   = int'(MODE0_DEF.h.fp),
  parameter int H0_SYNC = int'(MODE0_DEF.h.sync),
  parameter int H0_BP   = int'(MODE0_DEF.h.bp),
  parameter int V0_ACT  = int'(MODE0_DEF.v.act),
  parameter int V0_FP   = int'(MODE0_DEF.v.fp),
  parameter int V0_SYNC = int'(MODE0_DEF.v.sync),
  parameter int V0_BP   = int'(MODE0_DEF.v.bp),
  parameter int H1_ACT  = int'(MODE1_DEF.h.act),
  parameter int H1_FP   = int'(MODE1_DEF.h.fp),
  parameter int H1_SYNC = int'(MODE1_DEF.h.sync),
  parameter int H1_BP   = int'(MODE1_DEF.h.bp),
  parameter int V1_ACT  = int'(MODE1_DEF.v.act),
  parameter int V1_FP   = int'(MODE1_DEF.v.fp),
  parameter int V1_SYNC = int'(MODE1_DEF.v.sync),
  parameter int V1_BP   = int'(MODE1_DEF.v.bp),
  parameter int HS_POL0 = 0,
  parameter int VS_POL0 = 0,
  parameter int HS_POL1 = 1,
  parameter int VS_POL1 = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
  input  logic          mode_sel_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [CW-1:0] pixel_x_o,
  output logic [CW-1:0] pixel_y_o,
  output logic          line_start_o,
  output logic          frame_start_o,
  output logic          mode_cur_o
);

  localparam mode_t MODE0 = '{
    h: '{act: TW'(H0_ACT), fp: TW'(H0_FP), sync: TW'(H0_SYNC), bp: TW'(H0_BP), pol: 1'(HS_POL0)},
    v: '{act: TW'(V0_ACT), fp: TW'(V0_FP), sync: TW'(V0_SYNC), bp: TW'(V0_BP), pol: 1'(VS_POL0)}
  };
  localparam mode_t MODE1 = '{
    h: '{act: TW'(H1_ACT), fp: TW'(H1_FP), sync: TW'(H1_SYNC), bp: TW'(H1_BP), pol: 1'(HS_POL1)},
    v: '{act: TW'(V1_ACT), fp: TW'(V1_FP), sync: TW'(V1_SYNC), bp: TW'(V1_BP), pol: 1'(VS_POL1)}
  };

  localparam int TOT_A   = (total(MODE0.h) > total(MODE0.v)) ? total(MODE0.h) : total(MODE0.v);
  localparam int TOT_B   = (total(MODE1.h) > total(MODE1.v)) ? total(MODE1.h) : total(MODE1.v);
  localparam int MAX_TOT = (TOT_A > TOT_B) ? TOT_A : TOT_B;

  if (CW < $clog2(MAX_TOT)) begin : g_cw_too_small
    $error("vga_timing_gen: CW=%0d cannot hold a count of %0d", CW, MAX_TOT);
  end

  mode_t         cur;
  logic          mode_cur_q, mode_cur_d;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  logic          frame_end;

  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CW-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  assign cur       = mode_cur_q ? MODE1 : MODE0;
  assign frame_end = ce_i & h_wrap & v_wrap;

  vga_axis_counter #(.CW(CW)) u_h_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (ce_i),
    .tm_i     (cur.h),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .active_o (h_act)
  );

  vga_axis_counter #(.CW(CW)) u_v_axis (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (ce_i & h_wrap),
    .tm_i     (cur.v),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap),
    .sync_o   (v_sync),
    .active_o (v_act)
  );

  // Levels hold across ce=0 gaps; the start pulses clear so they last one clk
  always_comb begin
    mode_cur_d    = frame_end ? mode_sel_i : mode_cur_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (ce_i) begin
      hsync_d       = h_sync;
      vsync_d       = v_sync;
      de_d          = h_act & v_act;
      pixel_x_d     = (h_act & v_act) ? h_cnt : '0;
      pixel_y_d     = (h_act & v_act) ? v_cnt : '0;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_cur_q    <= mode_sel_i;
      hsync_q       <= mode_sel_i ? ~MODE1.h.pol : ~MODE0.h.pol;
      vsync_q       <= mode_sel_i ? ~MODE1.v.pol : ~MODE0.v.pol;
      de_q          <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      mode_cur_q    <= mode_cur_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign pixel_x_o     = pixel_x_q;
  assign pixel_y_o     = pixel_y_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign mode_cur_o    = mode_cur_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using small mode timings so whole
// frames, ce throttling, mode switches and mid-frame reset run quickly.
module tb_vga_timing_gen;

  localparam int CW = 6;

  // Mode 0: H 8/2/3/2 (15), V 4/1/2/1 (8), active-low syncs.
  // Mode 1: H 6/1/2/3 (12), V 3/2/1/2 (8), active-high syncs.
  int hAct[2]  = '{8, 6};
  int hFp[2]   = '{2, 1};
  int hSync[2] = '{3, 2};
  int hBp[2]   = '{2, 3};
  int vAct[2]  = '{4, 3};
  int vFp[2]   = '{1, 2};
  int vSync[2] = '{2, 1};
  int vBp[2]   = '{1, 2};
  bit hPol[2]  = '{1'b0, 1'b1};
  bit vPol[2]  = '{1'b0, 1'b1};

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          ls;
    logic          fs;
    logic          mode;
  } outs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce = 1'b0;
  logic          modeSel = 1'b0;
  logic          hsync, vsync, de, lineStart, frameStart, modeCur;
  logic [CW-1:0] pixelX, pixelY;

  int checks = 0;
  int errors = 0;

  outs_t sbQ[$];
  outs_t expOut;
  int    mh = 0;
  int    mv = 0;
  int    mMode = 0;

  int clkSinceFs = 0, fsPeriod = 0, deCnt = 0, lastDe = 0;
  int lastPx = 0, lastPy = 0, frameLastX = 0, frameLastY = 0;
  int hsRun = 0, hsLowRun = 0, hsHighRun = 0;
  logic prevHs = 1'b1;
  int lsRun = 0, lsMaxRun = 0, fsRun = 0, fsMaxRun = 0;

  vga_timing_gen #(
    .CW(CW),
    .H0_ACT(8), .H0_FP(2), .H0_SYNC(3), .H0_BP(2),
    .V0_ACT(4), .V0_FP(1), .V0_SYNC(2), .V0_BP(1),
    .H1_ACT(6), .H1_FP(1), .H1_SYNC(2), .H1_BP(3),
    .V1_ACT(3), .V1_FP(2), .V1_SYNC(1), .V1_BP(2),
    .HS_POL0(0), .VS_POL0(0), .HS_POL1(1), .VS_POL1(1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ce_i          (ce),
    .mode_sel_i    (modeSel),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .de_o          (de),
    .pixel_x_o     (pixelX),
    .pixel_y_o     (pixelY),
    .line_start_o  (lineStart),
    .frame_start_o (frameStart),
    .mode_cur_o    (modeCur)
  );

  always #5 clk = ~clk;

  // Drive one clock of inputs and queue the outputs expected after that edge
  task automatic applyStimulus(input logic r, input logic c, input logic m);
    int hTot, vTot, hs0, vs0;
    bit inH, inV;
    @(negedge clk);
    rst = r;
    ce = c;
    modeSel = m;
    if (r) begin
      expOut = '{hs: ~hPol[m], vs: ~vPol[m], de: 1'b0, px: '0, py: '0,
                 ls: 1'b0, fs: 1'b0, mode: m};
      mh = 0;
      mv = 0;
      mMode = int'(m);
    end else if (c) begin
      hTot = hAct[mMode] + hFp[mMode] + hSync[mMode] + hBp[mMode];
      vTot = vAct[mMode] + vFp[mMode] + vSync[mMode] + vBp[mMode];
      hs0 = hAct[mMode] + hFp[mMode];
      vs0 = vAct[mMode] + vFp[mMode];
      inH = (mh >= hs0) && (mh < hs0 + hSync[mMode]);
      inV = (mv >= vs0) && (mv < vs0 + vSync[mMode]);
      expOut.hs = inH ? hPol[mMode] : ~hPol[mMode];
      expOut.vs = inV ? vPol[mMode] : ~vPol[mMode];
      expOut.de = (mh < hAct[mMode]) && (mv < vAct[mMode]);
      expOut.px = expOut.de ? CW'(mh) : '0;
      expOut.py = expOut.de ? CW'(mv) : '0;
      expOut.ls = (mh == 0);
      expOut.fs = (mh == 0) && (mv == 0);
      if (mh == hTot - 1) begin
        mh = 0;
        if (mv == vTot - 1) begin
          mv = 0;
          mMode = int'(m);
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
      expOut.mode = mMode[0];
    end else begin
      expOut.ls = 1'b0;
      expOut.fs = 1'b0;
    end
    sbQ.push_back(expOut);
    @(posedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Scoreboard monitor: every clock presents a new output set to compare
  initial begin
    outs_t act, exp;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        exp = sbQ.pop_front();
        act = '{hs: hsync, vs: vsync, de: de, px: pixelX, py: pixelY,
                ls: lineStart, fs: frameStart, mode: modeCur};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL scoreboard t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b mode=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b mode=%b",
                   $time, act.hs, act.vs, act.de, act.px, act.py, act.ls, act.fs, act.mode,
                   exp.hs, exp.vs, exp.de, exp.px, exp.py, exp.ls, exp.fs, exp.mode);
        end
      end
    end
  end

  // Period, width and extent measurements taken on the DUT outputs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      clkSinceFs++;
      if (frameStart) begin
        fsPeriod = clkSinceFs;
        clkSinceFs = 0;
        lastDe = deCnt;
        deCnt = 0;
        frameLastX = lastPx;
        frameLastY = lastPy;
      end
      if (de) begin
        deCnt++;
        lastPx = int'(pixelX);
        lastPy = int'(pixelY);
      end
      if (hsync == prevHs) begin
        hsRun++;
      end else begin
        if (prevHs) hsHighRun = hsRun;
        else hsLowRun = hsRun;
        hsRun = 1;
        prevHs = hsync;
      end
      lsRun = lineStart ? lsRun + 1 : 0;
      fsRun = frameStart ? fsRun + 1 : 0;
      if (lsRun > lsMaxRun) lsMaxRun = lsRun;
      if (fsRun > fsMaxRun) fsMaxRun = fsRun;
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("reset_de", int'(de), 0);
    checkOutput("reset_hsync_inactive", int'(hsync), 1);

    // Mode 0, ce every clock
    for (int i = 0; i < 245; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("m0_frame_period", fsPeriod, 120);
    checkOutput("m0_de_per_frame", lastDe, 32);
    checkOutput("m0_last_x", frameLastX, 7);
    checkOutput("m0_last_y", frameLastY, 3);
    checkOutput("m0_hsync_low", hsLowRun, 3);
    checkOutput("m0_hsync_high", hsHighRun, 12);

    // Mode 0, ce one clock in four
    lsMaxRun = 0;
    fsMaxRun = 0;
    for (int i = 0; i < 1440; i++) applyStimulus(1'b0, (i % 4) == 0, 1'b0);
    #2;
    checkOutput("ce4_frame_period", fsPeriod, 480);
    checkOutput("ce4_de_clocks", lastDe, 128);
    checkOutput("ce4_hsync_low", hsLowRun, 12);
    checkOutput("ce4_hsync_high", hsHighRun, 48);
    checkOutput("ce4_line_pulse_width", lsMaxRun, 1);
    checkOutput("ce4_frame_pulse_width", fsMaxRun, 1);

    // Request mode 1 mid-frame; it takes effect at the next frame boundary
    for (int i = 0; i < 200 && !(mv == 2 && mh == 0); i++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("mode_held_mid_frame", int'(modeCur), 0);
    for (int i = 0; i < 408; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    #2;
    checkOutput("m1_mode_cur", int'(modeCur), 1);
    checkOutput("m1_frame_period", fsPeriod, 96);
    checkOutput("m1_de_per_frame", lastDe, 18);
    checkOutput("m1_last_x", frameLastX, 5);
    checkOutput("m1_last_y", frameLastY, 2);
    checkOutput("m1_hsync_high", hsHighRun, 2);
    checkOutput("m1_hsync_low", hsLowRun, 10);

    // Reset mid-frame with ce low, then restart
    for (int i = 0; i < 200 && !(mh == 3 && mv == 1); i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("midrst_de", int'(de), 0);
    checkOutput("midrst_hsync_inactive", int'(hsync), 0);
    checkOutput("midrst_vsync_inactive", int'(vsync), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("restart_frame_start", int'(frameStart), 1);
    checkOutput("restart_line_start", int'(lineStart), 1);
    checkOutput("restart_pixel_x", int'(pixelX), 0);
    checkOutput("restart_pixel_y", int'(pixelY), 0);
    checkOutput("restart_de", int'(de), 1);

    // Back to mode 0
    for (int i = 0; i < 340; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("back_m0_mode_cur", int'(modeCur), 0);
    checkOutput("back_m0_frame_period", fsPeriod, 120);

    repeat (2) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
